// File: rtl/muldiv_if.sv
// Start/busy/done handshake bundle between the RV32M multiply/divide unit and
// its requester (operand mux and stall control).
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, funct3, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, operand_a, operand_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add / restoring-divide steps per op.
// Optional MULDIV_EARLY_OUT_EN: div-by-zero, signed overflow and zero multiplies skip CALC.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t            state, state_nxt;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   hi, lo, mcand;
  logic [2:0]        op;
  logic              neg_q, neg_r, forced;
  logic [XLEN-1:0]   forced_val;

  logic              accept, in_div, a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   a_mag, b_mag, special_val;
  logic              div_zero, div_ovf, in_special, early;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, hi_step, lo_step, quo, rem, final_val;
  logic              div_ge;
  logic [2*XLEN-1:0] product, prod_signed;

  // Request decode: operand signedness, magnitudes and special-case detection at E0
  always_comb begin
    accept     = bus.start && ((state == IDLE) || (state == FIN));
    in_div     = bus.funct3[2];
    a_signed   = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed   = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
    sign_a     = a_signed & bus.operand_a[31];
    sign_b     = b_signed & bus.operand_b[31];
    a_mag      = sign_a ? (32'd0 - bus.operand_a) : bus.operand_a;
    b_mag      = sign_b ? (32'd0 - bus.operand_b) : bus.operand_b;
    div_zero   = in_div && (bus.operand_b == 32'd0);
    div_ovf    = in_div && ~bus.funct3[0] && (bus.operand_a == 32'h8000_0000)
                 && (bus.operand_b == 32'hFFFF_FFFF);
    in_special = div_zero | div_ovf;
    if (div_zero) begin
      special_val = bus.funct3[1] ? bus.operand_a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_val = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_val = 32'd0;
    end
`ifdef MULDIV_EARLY_OUT_EN
    early = in_special | (~in_div & ((bus.operand_a == 32'd0) | (bus.operand_b == 32'd0)));
`else
    early = 1'b0;
`endif
  end

  // One iteration step plus sign fix-up of the final step's outcome
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
    div_shift = {hi, lo[31]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift[31:0] - mcand;
    if (op[2]) begin
      hi_step = div_ge ? div_diff : div_shift[31:0];
      lo_step = {lo[30:0], div_ge};
    end else begin
      hi_step = mul_sum[32:1];
      lo_step = {mul_sum[0], lo[31:1]};
    end
    product     = {hi_step, lo_step};
    prod_signed = neg_q ? (64'd0 - product) : product;
    quo         = neg_q ? (32'd0 - lo_step) : lo_step;
    rem         = neg_r ? (32'd0 - hi_step) : hi_step;
    case (op)
      3'b000:  final_val = prod_signed[31:0];
      3'b001,
      3'b010,
      3'b011:  final_val = prod_signed[63:32];
      3'b100,
      3'b101:  final_val = quo;
      3'b110,
      3'b111:  final_val = rem;
      default: final_val = 32'd0;
    endcase
    if (forced) begin
      final_val = forced_val;
    end else begin
      final_val = final_val;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state; FIN accepts a new request exactly like IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = early ? FIN : CALC;
        else           state_nxt = IDLE;
      end
      CALC: begin
        if (cnt == LAST) state_nxt = FIN;
        else             state_nxt = CALC;
      end
      FIN: begin
        if (bus.start) state_nxt = early ? FIN : CALC;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, counter and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= 32'd0;
      cnt        <= 5'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      mcand      <= 32'd0;
      op         <= 3'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      forced     <= 1'b0;
      forced_val <= 32'd0;
    end else begin
      bus.busy <= (state_nxt == CALC);
      bus.done <= (state_nxt == FIN);
      if (accept) begin
        hi         <= 32'd0;
        lo         <= a_mag;
        mcand      <= b_mag;
        op         <= bus.funct3;
        neg_q      <= sign_a ^ sign_b;
        neg_r      <= sign_a;
        forced     <= in_special | early;
        forced_val <= special_val;
        cnt        <= 5'd0;
        if (early) bus.result <= special_val;
      end else if (state == CALC) begin
        hi  <= hi_step;
        lo  <= lo_step;
        cnt <= cnt + 5'd1;
        if (cnt == LAST) bus.result <= final_val;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, handshake, reset abort.
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and hold start across one rising edge (E0); returns at E0+1
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.funct3    = f;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called at E0+1; returns at the sampling point of the done cycle
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int n;
    int busy_cnt;
    n = 1;
    busy_cnt = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, "_res"}, bus.result, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    launch(f, a, b);
    wait_done(tag, exp_lat, exp_res);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dcount;
    clk = 1'b0;
    reset = 1'b0;
    n_cmp = 0;
    n_err = 0;
    bus.start = 1'b0;
    bus.funct3 = 3'd0;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // MUL 7 * -3, then result must be held with done low
    launch(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul", 33, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    check("mul_hold_res", bus.result, 32'hFFFF_FFEB);
    check("mul_hold_done", 32'(bus.done), 32'd0);
    check("mul_hold_busy", 32'(bus.busy), 32'd0);

    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFF);

    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run_op("divu", 3'b101, 32'd100, 32'd7, 33, 32'd14);
    run_op("remu", 3'b111, 32'd100, 32'd7, 33, 32'd2);

    run_op("divu_z", 3'b101, 32'd5, 32'd0, SPEC_LAT, 32'hFFFF_FFFF);
    run_op("remu_z", 3'b111, 32'd5, 32'd0, SPEC_LAT, 32'd5);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, SPEC_LAT, 32'h8000_0000);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, SPEC_LAT, 32'd0);

    // start while busy is ignored; operand lines wander afterwards
    launch(3'b000, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    launch(3'b100, 32'd100, 32'd5);
    bus.operand_a = 32'hDEAD_BEEF;
    bus.operand_b = 32'h1234_5678;
    bus.funct3 = 3'b111;
    wait_done("ign", 23, 32'd12);

    // start during done cycle begins a new op immediately
    launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_done", 32'(bus.done), 32'd0);
    check("b2b_keep", bus.result, 32'd12);
    wait_done("b2b", 33, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;

    // reset at cycle 15 of a DIV aborts it with no done pulse
    launch(3'b100, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    run_op("post_rst", 3'b101, 32'd100, 32'd7, 33, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, downstream of the operand mux, in parallel with the ALU.
- Takes operand A from register-file ReadData1 and operand B from the ALU-source mux output.
- Produces a 32-bit result through a start/busy/done handshake.
- Control stalls PC update while busy is high.

Parameters:
- XLEN, 32, operand/result width; the only supported value is 32.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  input  32  rs1 value / dividend
- operand_b  input  32  rs2 value / divisor
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- result  output  32  final value, held until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal accumulators and counter cleared.
  - Takes effect mid-operation: the operation is aborted and no done pulse follows.
- States:
  - IDLE: start=1 at edge E0 latches operand_a, operand_b and funct3, then goes to CALC; busy=1 from E0.
  - CALC: one iteration per edge, 5-bit counter; after the 32nd iteration (edge E32) goes to FIN.
  - FIN: done=1 and busy=0 for exactly one cycle; result register written at E32; at E33 returns to IDLE.
  - start=1 while in FIN is accepted exactly as in IDLE; done still pulses only once.
- Latency: start at E0 gives done high in the cycle after E32 (33 cycles); the unit is fully serial.
- start while busy=1 is ignored; latched operands and funct3 do not change.
- Operands and funct3 may change freely after E0.
- Multiply:
  - Shift-add on operand magnitudes into a 64-bit product.
  - Product negated when the operand signs differ.
  - Signedness: MUL/MULH signed×signed; MULHSU signed a × unsigned b; MULHU unsigned×unsigned.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide:
  - Restoring division on magnitudes.
  - Quotient negated when signs differ (DIV only); remainder takes the dividend's sign (REM only).
  - DIVU/REMU treat both operands as unsigned.
- Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = operand_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- Special cases are detected at E0 and forced into result at completion; they never raise errors.
- Without the optional feature they keep the full 33-cycle latency.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Divide-by-zero, signed overflow, and multiply with either operand zero skip CALC.
  - E0 goes directly to FIN; done is high in the cycle after E0 and result is written at E0.
  - All other operations keep 33 cycles.
- Undefined: every operation takes exactly 33 cycles. Results are identical either way; only the timing differs.

Test Plan:
- Reset and MUL: reset=0 then release. MUL a=7, b=0xFFFFFFFD (−3). Required: busy=1 for 32 cycles, done pulse in cycle 33, result=0xFFFFFFEB, held afterwards.
- High-word multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- Signed divide: DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Each case: done at cycle 33 without the macro, cycle 1 with it.
- Handshake:
  - Assert start with new operands at cycle 10 of a busy MUL 3×4 → ignored; result=12.
  - Start asserted during the done cycle begins a new operation; busy=1 on the next cycle.
- Reset mid-operation: drive reset=0 at cycle 15 of a DIV → busy=0, done=0, result=0 immediately; no done pulse afterwards; the next start completes normally.
